mux_4x1: RTL and testbench



---
 rtl/mux_4x1.sv | 79 +++++++
 tb/tb_mux_4x1.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux_4x1.sv
// -----------------------------------------------------------------------------
// mux_4x1
//
// Single-bit 4-to-1 selector. The combinational output Y follows A[S] with
// zero latency and is the primary result used by downstream logic. A
// registered copy Y_q, together with a registered one-hot decode of the
// select (S_dec_q), gives clocked consumers a glitch-free, reset-defined view
// of the same selection. Leaf cell: no submodules.
//
// Ports
//   clk      in   1  rising-edge clock; clocks Y_q and S_dec_q only
//   rst      in   1  asynchronous, active-high reset; clears Y_q and S_dec_q
//   A        in   4  data inputs; A[i] is selected when S == i
//   S        in   2  select, unsigned index 0..3 into A
//   en       in   1  capture enable for the registered outputs
//   Y        out  1  combinational A[S]
//   Y_q      out  1  registered A[S]
//   S_dec    out  4  combinational one-hot decode, S_dec[i] = (S == i)
//   S_dec_q  out  4  registered S_dec; 4'b0000 means "nothing captured since
//                    reset" and is the only legal non-one-hot value
// -----------------------------------------------------------------------------
module mux_4x1 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [1:0] S,
  input  logic       en,
  output logic       Y,
  output logic       Y_q,
  output logic [3:0] S_dec,
  output logic [3:0] S_dec_q
);

  // Data select. Every legal S code is listed explicitly, so there is no
  // silent default-to-zero leg. The only remaining path is a non-0/1 select,
  // which drives X so an unknown select stays visible as X on Y. Unselected
  // A bits never reach Y, so X/Z on them cannot disturb the output.
  // NOTE: assigning Y before the case gives it a value on every path through
  // the block; a combinational output left unassigned on some path infers a
  // latch.
  always_comb begin
    Y = 1'bx;
    case (S)
      2'b00:   Y = A[0];
      2'b01:   Y = A[1];
      2'b10:   Y = A[2];
      2'b11:   Y = A[3];
      default: Y = 1'bx;
    endcase
  end

  // One-hot decode of the select. Exactly one bit is set for every legal S;
  // an unknown select decodes to all-X rather than to a plausible code.
  always_comb begin
    S_dec = 4'bxxxx;
    case (S)
      2'b00:   S_dec = 4'b0001;
      2'b01:   S_dec = 4'b0010;
      2'b10:   S_dec = 4'b0100;
      2'b11:   S_dec = 4'b1000;
      default: S_dec = 4'bxxxx;
    endcase
  end

  // Registered copies. Reset wins immediately, independent of clk and en;
  // with en low the registers simply keep their contents.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y_q     <= 1'b0;
      S_dec_q <= 4'b0000;
    end else if (en) begin
      Y_q     <= Y;
      S_dec_q <= S_dec;
    end
  end

endmodule

// File: tb/tb_mux_4x1.sv
// -----------------------------------------------------------------------------
// tb_mux_4x1
//
// Self-checking bench for mux_4x1: directed steps following the block's
// intended behaviour, then a randomized run compared against a behavioural
// model that works directly from the selection rules (shift-and-mask for Y,
// shifted one for the decode, plain variables for the captured values).
// -----------------------------------------------------------------------------
module tb_mux_4x1;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [1:0] S;
  logic       en;
  logic       Y;
  logic       Y_q;
  logic [3:0] S_dec;
  logic [3:0] S_dec_q;

  int vectors     = 0;
  int miscompares = 0;

  // Model of the registered outputs.
  logic       mdl_yq;
  logic [3:0] mdl_dec_q;

  bit clk_on = 1'b0;

  mux_4x1 dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .S       (S),
    .en      (en),
    .Y       (Y),
    .Y_q     (Y_q),
    .S_dec   (S_dec),
    .S_dec_q (S_dec_q)
  );

  // The clock stays undriven until the combinational phase is done.
  initial begin
    wait (clk_on);
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural reference: selection as arithmetic on the raw vectors.
  function automatic logic ref_y(input logic [3:0] a, input logic [1:0] s);
    return logic'((a >> s) & 4'b0001);
  endfunction

  function automatic logic [3:0] ref_dec(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag);
    check({tag, " Y"}, {3'b000, Y}, {3'b000, ref_y(A, S)});
    check({tag, " S_dec"}, S_dec, ref_dec(S));
  endtask

  task automatic check_regs(input string tag);
    check({tag, " Y_q"}, {3'b000, Y_q}, {3'b000, mdl_yq});
    check({tag, " S_dec_q"}, S_dec_q, mdl_dec_q);
  endtask

  // Advance to the next rising edge and update the model as the edge would.
  task automatic clock_edge();
    logic       y_before;
    logic [3:0] d_before;
    y_before = ref_y(A, S);
    d_before = ref_dec(S);
    @(posedge clk);
    if (!rst && en) begin
      mdl_yq    = y_before;
      mdl_dec_q = d_before;
    end
    #1;
  endtask

  initial begin
    // ---------------- combinational only, clk and rst undriven -------------
    $monitor("%0t A=%b S=%b Y=%b S_dec=%b", $time, A, S, Y, S_dec);
    en = 1'b0;
    A = 4'b0000; S = 2'b00; #1; check("sel00", {3'b000, Y}, 4'b0000);
    A = 4'b0010; S = 2'b01; #1; check("sel01", {3'b000, Y}, 4'b0001);
    A = 4'b0100; S = 2'b10; #1; check("sel10", {3'b000, Y}, 4'b0001);
    A = 4'b1000; S = 2'b11; #1; check("sel11", {3'b000, Y}, 4'b0001);

    // Unselected-bit isolation.
    A = 4'b1110; S = 2'b00; #1; check("iso_a1110_s0", {3'b000, Y}, 4'b0000);
    A = 4'b0001; S = 2'b01; #1; check("iso_a0001_s1", {3'b000, Y}, 4'b0000);
    S = 2'b00;
    for (int i = 0; i < 8; i++) begin
      A = {3'(i), 1'b0};
      #1; check("iso_toggle_hi", {3'b000, Y}, 4'b0000);
    end

    // Decode sweep.
    check("dec00", S_dec, 4'b0001);
    S = 2'b01; #1; check("dec01", S_dec, 4'b0010);
    S = 2'b10; #1; check("dec10", S_dec, 4'b0100);
    S = 2'b11; #1; check("dec11", S_dec, 4'b1000);
    $monitoroff;

    // ---------------- registered path -------------------------------------
    rst = 1'b1;
    clk_on = 1'b1;
    en = 1'b1;
    mdl_yq = 1'b0; mdl_dec_q = 4'b0000;
    repeat (2) @(negedge clk);
    check("rst Y_q", {3'b000, Y_q}, 4'b0000);
    check("rst S_dec_q", S_dec_q, 4'b0000);

    rst = 1'b0; A = 4'b1000; S = 2'b11; en = 1'b1;
    clock_edge();
    check("cap Y_q", {3'b000, Y_q}, 4'b0001);
    check("cap S_dec_q", S_dec_q, 4'b1000);

    // Hold with en low: Y drops at once, Y_q keeps its value for 3 edges.
    @(negedge clk);
    en = 1'b0; A = 4'b0000;
    #1; check("hold Y", {3'b000, Y}, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      clock_edge();
      check("hold Y_q", {3'b000, Y_q}, 4'b0001);
      check("hold S_dec_q", S_dec_q, 4'b1000);
    end

    // Async reset mid-run, between edges, with Y_q at 1.
    @(negedge clk);
    rst = 1'b1; A = 4'b0100; S = 2'b10; en = 1'b1;
    #1;
    mdl_yq = 1'b0; mdl_dec_q = 4'b0000;
    check("async Y_q", {3'b000, Y_q}, 4'b0000);
    check("async S_dec_q", S_dec_q, 4'b0000);
    check("async Y", {3'b000, Y}, 4'b0001);
    check("async S_dec", S_dec, 4'b0100);
    clock_edge();
    check("rst held Y_q", {3'b000, Y_q}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    clock_edge();
    check_regs("post-rst capture");

    // ---------------- randomized run against the model ---------------------
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      A  = 4'($urandom);
      S  = 2'($urandom);
      en = 1'($urandom_range(0, 3) != 0);
      #1;
      check_comb("rand comb");
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        #1;
        mdl_yq = 1'b0; mdl_dec_q = 4'b0000;
        check_regs("rand async rst");
        rst = 1'b0;
      end
      clock_edge();
      check_regs("rand reg");
      check_comb("rand comb post-edge");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog: the bench must always end by itself.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
